// File: rtl/t_counter_mod.sv
// ---------------------------------------------------------------------------
// t_counter_mod
//
// Purpose:
//   WIDTH-bit modulo counter built from per-bit toggle stages. Each bit is a
//   T stage whose toggle condition comes from the mode and the lower-order
//   bits. The counter counts up or down modulo MODULUS, loads a saturated
//   value, and flags wraps with a combinational terminal-count strobe and a
//   sticky overflow flag. All state changes on the falling edge of clk,
//   matching the team's flip-flop library.
//
// Parameters:
//   WIDTH    counter width in bits (1..16)
//   MODULUS  count range 0..MODULUS-1 (2..2^WIDTH)
//
// Ports:
//   clk       in   clock, state updates on the falling edge
//   reset     in   synchronous active-high reset, overrides everything
//   en        in   count enable for modes 01/10
//   mode      in   00 hold, 01 up, 10 down, 11 load
//   load_val  in   value loaded in mode 11 (saturates to MODULUS-1)
//   clr_ovf   in   clears the sticky ovf flag (a wrap on the same edge wins)
//   out       out  current count (registered)
//   tc        out  terminal count (combinational, ahead of the wrapping edge)
//   ovf       out  sticky wrap flag (registered)
// ---------------------------------------------------------------------------
module t_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  localparam logic [1:0]       MODE_HOLD = 2'b00;
  localparam logic [1:0]       MODE_UP   = 2'b01;
  localparam logic [1:0]       MODE_DOWN = 2'b10;
  localparam logic [1:0]       MODE_LOAD = 2'b11;
  localparam logic [WIDTH-1:0] MAX_C     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] tog;
  logic             up_en, dn_en, wrap;

  // Decode counting direction and detect a modulus wrap on the coming edge.
  always_comb begin
    up_en = en & (mode == MODE_UP);
    dn_en = en & (mode == MODE_DOWN);
    wrap  = (up_en & (out_q == MAX_C)) | (dn_en & (out_q == ZERO_C));
    tc    = wrap;
  end

  // Per-bit toggle conditions: bit i toggles when all lower bits are 1 (up)
  // or all lower bits are 0 (down); bit 0 sees an empty prefix and always
  // toggles while counting.
  always_comb begin
    logic ones_pfx;
    logic zeros_pfx;
    ones_pfx  = 1'b1;
    zeros_pfx = 1'b1;
    tog       = ZERO_C;
    for (int i = 0; i < WIDTH; i++) begin
      tog[i]    = (up_en & ones_pfx) | (dn_en & zeros_pfx);
      ones_pfx  = ones_pfx & out_q[i];
      zeros_pfx = zeros_pfx & ~out_q[i];
    end
  end

  // Next-state selection: load > wrap > toggle count > hold.
  always_comb begin
    out_d = out_q;
    case (mode)
      MODE_LOAD: begin
        if (load_val > MAX_C) begin
          out_d = MAX_C;
        end else begin
          out_d = load_val;
        end
      end
      MODE_UP: begin
        if (wrap) begin
          out_d = ZERO_C;
        end else begin
          out_d = out_q ^ tog;
        end
      end
      MODE_DOWN: begin
        if (wrap) begin
          out_d = MAX_C;
        end else begin
          out_d = out_q ^ tog;
        end
      end
      MODE_HOLD: begin
        out_d = out_q;
      end
      default: begin
        out_d = out_q;
      end
    endcase
    // A wrap sets ovf even when clr_ovf is asserted on the same edge.
    ovf_d = wrap | (ovf_q & ~clr_ovf);
  end

  // State registers on the falling edge; reset overrides every other input.
  always_ff @(negedge clk) begin
    if (reset) begin
      out_q <= ZERO_C;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = out_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_t_counter_mod.sv
// ---------------------------------------------------------------------------
// tb_t_counter_mod
//
// Self-checking bench for t_counter_mod. Two instances share one stimulus
// stream: A (WIDTH=4, MODULUS=10) and B (WIDTH=3, MODULUS=8). A reference
// model based on modular arithmetic tracks both counters; a compare process
// checks out/tc/ovf of both instances every cycle, and directed steps pin
// the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_t_counter_mod;

  localparam int MOD_A = 10;
  localparam int MOD_B = 8;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic       clr_ovf;
  logic [3:0] out_a;
  logic [2:0] out_b;
  logic       tc_a, tc_b, ovf_a, ovf_b;

  int n_vec;
  int n_err;
  bit chk_en;

  // Reference model state
  int m_out_a, m_out_b;
  int m_ovf_a, m_ovf_b;

  t_counter_mod #(.WIDTH(4), .MODULUS(MOD_A)) dut_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load_val(load_val),
    .clr_ovf(clr_ovf), .out(out_a), .tc(tc_a), .ovf(ovf_a)
  );

  t_counter_mod #(.WIDTH(3), .MODULUS(MOD_B)) dut_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load_val(load_val[2:0]),
    .clr_ovf(clr_ovf), .out(out_b), .tc(tc_b), .ovf(ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int model_tc(input int cnt, input int m);
    return (en && ((mode == 2'd1 && cnt == m - 1) || (mode == 2'd2 && cnt == 0))) ? 1 : 0;
  endfunction

  task automatic model_next(inout int cnt, inout int fl, input int m, input int lv);
    int w;
    w = model_tc(cnt, m);
    if (reset) begin
      cnt = 0;
      fl  = 0;
    end else begin
      case (mode)
        2'd3:    cnt = (lv >= m) ? m - 1 : lv;
        2'd1:    if (en) cnt = (cnt + 1) % m;
        2'd2:    if (en) cnt = (cnt + m - 1) % m;
        default: cnt = cnt;
      endcase
      if (w != 0)       fl = 1;
      else if (clr_ovf) fl = 0;
    end
  endtask

  // Model advances on the same falling edge as the DUT.
  always @(negedge clk) begin
    model_next(m_out_a, m_ovf_a, MOD_A, int'(load_val));
    model_next(m_out_b, m_ovf_b, MOD_B, int'(load_val[2:0]));
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, mid-way between the input change and falling edge.
  always @(posedge clk) begin
    #3;
    if (chk_en) begin
      cmp("a_out", int'(out_a), m_out_a);
      cmp("a_ovf", int'(ovf_a), m_ovf_a);
      cmp("a_tc",  int'(tc_a),  model_tc(m_out_a, MOD_A));
      cmp("b_out", int'(out_b), m_out_b);
      cmp("b_ovf", int'(ovf_b), m_ovf_b);
      cmp("b_tc",  int'(tc_b),  model_tc(m_out_b, MOD_B));
    end
  end

  // Apply inputs after a rising edge and return just after the falling edge.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] lv, input logic c);
    @(posedge clk);
    #1;
    reset    = r;
    en       = e;
    mode     = m;
    load_val = lv;
    clr_ovf  = c;
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    m_out_a  = 0;
    m_out_b  = 0;
    m_ovf_a  = 0;
    m_ovf_b  = 0;
    reset    = 1'b1;
    en       = 1'b0;
    mode     = 2'd0;
    load_val = 4'd0;
    clr_ovf  = 1'b0;

    // Reset for two edges
    step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    cmp("rst_out", int'(out_a), 0);
    cmp("rst_ovf", int'(ovf_a), 0);
    cmp("rst_tc",  int'(tc_a),  0);

    // Count up 12 edges through the 9 -> 0 wrap
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b1, 2'd1, 4'd0, 1'b0);
      cmp("up_out", int'(out_a), k % 10);
      if (k == 9) begin
        cmp("up_tc9",   int'(tc_a),  1);
        cmp("up_ovf9",  int'(ovf_a), 0);
      end
      if (k == 10) begin
        cmp("up_ovf10", int'(ovf_a), 1);
        cmp("up_tc0",   int'(tc_a),  0);
      end
    end
    cmp("up_ovf_sticky", int'(ovf_a), 1);

    // Clear ovf without a wrap
    step(1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
    cmp("clr_ovf", int'(ovf_a), 0);
    cmp("clr_out", int'(out_a), 2);

    // Load 0 then count down through the 0 -> 9 wrap
    step(1'b0, 1'b0, 2'd3, 4'd0, 1'b0);
    cmp("ld0_out", int'(out_a), 0);
    step(1'b0, 1'b1, 2'd2, 4'd0, 1'b0);
    cmp("dn_wrap_out", int'(out_a), 9);
    cmp("dn_wrap_ovf", int'(ovf_a), 1);
    step(1'b0, 1'b1, 2'd2, 4'd0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 4'd0, 1'b0);
    cmp("dn_out7", int'(out_a), 7);
    step(1'b0, 1'b1, 2'd0, 4'd0, 1'b1);
    cmp("dn_clr_ovf", int'(ovf_a), 0);

    // Loads: saturating and in-range, ovf untouched
    step(1'b0, 1'b1, 2'd3, 4'd12, 1'b0);
    cmp("ld12_out", int'(out_a), 9);
    cmp("ld12_ovf", int'(ovf_a), 0);
    step(1'b0, 1'b0, 2'd3, 4'd7, 1'b0);
    cmp("ld7_out", int'(out_a), 7);
    cmp("ld7_ovf", int'(ovf_a), 0);

    // en=0 in up mode, then mode 00 with en=1: both hold
    step(1'b0, 1'b0, 2'd3, 4'd5, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 2'd1, 4'd0, 1'b0);
    end
    cmp("en0_out", int'(out_a), 5);
    cmp("en0_tc",  int'(tc_a),  0);
    step(1'b0, 1'b1, 2'd0, 4'd0, 1'b0);
    cmp("hold_out", int'(out_a), 5);

    // Wrap with clr_ovf on the same edge: set wins; next clr clears
    step(1'b0, 1'b0, 2'd3, 4'd9, 1'b0);
    step(1'b0, 1'b1, 2'd1, 4'd0, 1'b1);
    cmp("wclr_out", int'(out_a), 0);
    cmp("wclr_ovf", int'(ovf_a), 1);
    step(1'b0, 1'b1, 2'd1, 4'd0, 1'b1);
    cmp("nclr_out", int'(out_a), 1);
    cmp("nclr_ovf", int'(ovf_a), 0);

    // WIDTH=3/MODULUS=8 instance: reset mid-count
    step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 2'd1, 4'd0, 1'b0);
    end
    cmp("b_up6", int'(out_b), 6);
    step(1'b1, 1'b1, 2'd1, 4'd0, 1'b0);
    cmp("b_rst_out", int'(out_b), 0);
    cmp("b_rst_ovf", int'(ovf_b), 0);
    step(1'b0, 1'b1, 2'd1, 4'd0, 1'b0);
    cmp("b_post1", int'(out_b), 1);
    step(1'b0, 1'b1, 2'd1, 4'd0, 1'b0);
    cmp("b_post2", int'(out_b), 2);

    // Randomized phase, checked every cycle by the compare process
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    @(posedge clk);
    #4;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/t_counter_mod.md
# t_counter_mod

Parametrised WIDTH-bit modulo counter built from toggle cells: each bit is a T stage whose toggle condition comes from the mode and the lower-order bits. It generalises the team's single-bit toggle flip-flop to a multi-bit up/down/load counter with a configurable modulus, a terminal-count strobe and a sticky wrap flag. It serves as the standard divider/sequencer primitive for the team's sequential blocks.

## Interface
- WIDTH, 4, counter width in bits; legal range 1..16.
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- clk  input  1  clock; all state updates on the falling edge of clk, matching the team's flip-flop library.
- reset  input  1  synchronous, active-high reset; sampled on the falling edge of clk; overrides every other input.
- en  input  1  count enable; when low, `out` holds in modes 01 and 10.
- mode  input  2  00 hold, 01 count up, 10 count down, 11 load.
- load_val  input  WIDTH  value loaded in mode 11.
- clr_ovf  input  1  clears the sticky `ovf` flag.
- out  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational from registered state and inputs).
- ovf  output  1  sticky wrap flag (registered).

## Operation
- Per-bit toggle form: in up mode, bit i toggles when en=1 and bits 0..i-1 are all 1. In down mode, bit i toggles when en=1 and bits 0..i-1 are all 0. Bit 0 toggles whenever counting is enabled.
- Modulus wrap overrides toggling:
  - up at out=MODULUS-1 → next out=0;
  - down at out=0 → next out=MODULUS-1.
- When MODULUS=2^WIDTH, the wrap produces the same result as natural toggle overflow.
- Mode 00: out holds regardless of en.
- Mode 11: loads on the next edge regardless of en.
  - load_val ≤ MODULUS-1 → out=load_val.
  - load_val ≥ MODULUS → out saturates to MODULUS-1.
  - A load never sets ovf.
- tc = en & ((mode==01 & out==MODULUS-1) | (mode==10 & out==0)); it is 0 in modes 00 and 11.
- ovf is set on every edge where a wrap occurs, i.e. on an edge where tc=1.
  - clr_ovf=1 clears ovf on that edge.
  - Wrap and clr_ovf on the same edge: set wins, ovf=1.
- Priority per edge: reset > mode 11 load > wrap > toggle count > hold.
- reset=1: out=0, ovf=0 on that edge. tc therefore evaluates to 1 only if the inputs select down mode with en=1 while out=0.

## Timing
- Reset values: out=0, ovf=0; tc is combinational (0 with en=0).
- Latency: mode, en, load_val and clr_ovf take effect on out/ovf at the first falling edge after they are applied. No pipeline stages are inserted.
- tc is valid in the same cycle as the out value it describes, ahead of the wrapping edge. Downstream logic samples tc on the same falling edge that performs the wrap.
- Inputs must be stable around the falling edge. Rising-edge changes are permitted.
- Reset mid-count: the count is abandoned on the reset edge and restarts at 0 on the first edge after reset deasserts. ovf is lost.
- Mode change mid-count (up → down): takes effect on the next edge from the current value. There are no hidden pipeline states.

## Test plan
- WIDTH=4, MODULUS=10, reset 2 edges then mode=01, en=1 for 12 edges → out 0,1,…,9,0,1. tc high only while out=9. ovf rises at the 9→0 edge and stays 1.
- Same config, mode=10 from out=0 → out 9,8,…. tc high at out=0, then ovf=1. Pulse clr_ovf with no wrap → ovf=0 next edge.
- mode=11, load_val=7 → out=7 next edge. load_val=12 (≥MODULUS) → out=9. ovf unchanged in both cases.
- en=0 in mode 01 for 5 edges at out=5 → out stays 5, tc=0. Mode 00 with en=1 → out also holds.
- Wrap edge (out=9, up, en=1) with clr_ovf=1 → out=0, ovf=1. Next edge with clr_ovf=1 and no wrap → ovf=0.
- WIDTH=3, MODULUS=8, count up to 6, then assert reset for one edge with mode=01 → out=0, ovf=0. Deassert → out 1,2,….
